// File: rtl/musa_pkg.sv
// Shared MUSA core constants: datapath width and the call/ret opcodes decoded by the control unit.
package musa_pkg;

   localparam int unsigned ADDR_W = 32;

   localparam logic [5:0] OP_CALL = 6'b000011;
   localparam logic [5:0] OP_RET  = 6'b000111;

endpackage : musa_pkg

// File: rtl/return_addr_stack_if.sv
// Control-unit <-> return-address-stack bus: push/pop strobes in, return address and status out.
interface return_addr_stack_if #(
   parameter int unsigned ADDR_W = musa_pkg::ADDR_W,
   parameter int unsigned DEPTH  = 8
);
   localparam int unsigned DW = $clog2(DEPTH + 1);

   logic              push;
   logic              pop;
   logic              flush;
   logic              err_clr;
   logic [ADDR_W-1:0] call_pc;
   logic [ADDR_W-1:0] ret_pc;
   logic              ret_valid;
   logic              empty;
   logic              full;
   logic [DW-1:0]     depth;
   logic              overflow;
   logic              underflow;

   modport master (
      output push, pop, flush, err_clr, call_pc,
      input  ret_pc, ret_valid, empty, full, depth, overflow, underflow
   );

   modport slave (
      input  push, pop, flush, err_clr, call_pc,
      output ret_pc, ret_valid, empty, full, depth, overflow, underflow
   );

endinterface : return_addr_stack_if

// File: rtl/ras_storage.sv
// DEPTH x ADDR_W register array, one write port and one asynchronous read port at the top-of-stack index.
module ras_storage #(
   parameter int unsigned ADDR_W = musa_pkg::ADDR_W,
   parameter int unsigned DEPTH  = 8
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [ADDR_W-1:0]        wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [ADDR_W-1:0]        rdata_c
);

   logic [ADDR_W-1:0] mem [DEPTH];

   // Contents need no reset: an entry is always written before the pointer exposes it.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata_c = mem[raddr];

endmodule : ras_storage

// File: rtl/return_addr_stack.sv
// Return-address stack for call/ret: pointer, occupancy state and sticky error flags around ras_storage.
module return_addr_stack #(
   parameter int unsigned ADDR_W     = musa_pkg::ADDR_W,
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned RET_OFFSET = 1
) (
   input  logic                clk,
   input  logic                rst,
   return_addr_stack_if.slave  bus
);

   localparam int unsigned DW = $clog2(DEPTH + 1);
   localparam int unsigned AW = $clog2(DEPTH);

   // Encoded so that bit 0 is the empty flag and bit 1 the full flag.
   localparam logic [1:0] S_PARTIAL = 2'b00;
   localparam logic [1:0] S_EMPTY   = 2'b01;
   localparam logic [1:0] S_FULL    = 2'b10;

   logic [1:0]        state_q, state_d;
   logic [DW-1:0]     sp_q, sp_d;
   logic [ADDR_W-1:0] ret_pc_q, ret_pc_d;
   logic              ret_valid_q, ret_valid_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;

   logic              mem_we;
   logic [AW-1:0]     mem_waddr;
   logic [AW-1:0]     top_idx;
   logic [ADDR_W-1:0] top_data;
   logic [ADDR_W-1:0] new_val;
   logic              is_empty;
   logic              is_full;

   assign is_empty = state_q[0];
   assign is_full  = state_q[1];
   assign top_idx  = AW'(sp_q - DW'(1));
   assign new_val  = ADDR_W'(bus.call_pc + ADDR_W'(RET_OFFSET));

   ras_storage #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_storage (
      .clk     (clk),
      .we      (mem_we),
      .waddr   (mem_waddr),
      .wdata   (new_val),
      .raddr   (top_idx),
      .rdata_c (top_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_EMPTY;
         sp_q        <= '0;
         ret_pc_q    <= '0;
         ret_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         sp_q        <= sp_d;
         ret_pc_q    <= ret_pc_d;
         ret_valid_q <= ret_valid_d;
         ovf_q       <= ovf_d;
         unf_q       <= unf_d;
      end
   end

   // Next-state: flush beats push/pop; a same-cycle error beats err_clr.
   always_comb begin
      sp_d        = sp_q;
      state_d     = state_q;
      ret_pc_d    = ret_pc_q;
      ret_valid_d = 1'b0;
      ovf_d       = ovf_q & ~bus.err_clr;
      unf_d       = unf_q & ~bus.err_clr;
      mem_we      = 1'b0;
      mem_waddr   = top_idx;

      if (bus.flush) begin
         sp_d = '0;
      end else begin
         case ({bus.push, bus.pop})
            2'b10: begin
               if (is_full) begin
                  ovf_d = 1'b1;
               end else begin
                  mem_we    = 1'b1;
                  mem_waddr = AW'(sp_q);
                  sp_d      = sp_q + DW'(1);
               end
            end
            2'b01: begin
               if (is_empty) begin
                  unf_d = 1'b1;
               end else begin
                  ret_pc_d    = top_data;
                  ret_valid_d = 1'b1;
                  sp_d        = sp_q - DW'(1);
               end
            end
            2'b11: begin
               ret_valid_d = 1'b1;
               if (is_empty) begin
                  ret_pc_d = new_val;
               end else begin
                  ret_pc_d = top_data;
                  mem_we   = 1'b1;
               end
            end
            default: ;
         endcase
      end

      if (sp_d == '0)                 state_d = S_EMPTY;
      else if (sp_d == DW'(DEPTH))    state_d = S_FULL;
      else                            state_d = S_PARTIAL;
   end

   assign bus.ret_pc    = ret_pc_q;
   assign bus.ret_valid = ret_valid_q;
   assign bus.empty     = state_q[0];
   assign bus.full      = state_q[1];
   assign bus.depth     = sp_q;
   assign bus.overflow  = ovf_q;
   assign bus.underflow = unf_q;

endmodule : return_addr_stack
